// File: rtl/window_extrema_pkg.sv
// rtl/window_extrema_pkg.sv - shared state encoding and width helpers for window_extrema
package window_extrema_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int cw_of(input int depth);
        return clog2(depth + 1);
    endfunction

    // A win only counts when the comparator also rules out a tie and the opposite order.
    function automatic logic strict_win(input logic win, input logic tie, input logic lose);
        return win & ~tie & ~lose;
    endfunction

endpackage

// File: rtl/window_extrema_cmp_core.sv
// rtl/window_extrema_cmp_core.sv - combinational signed/unsigned magnitude comparator
module cmp_core #(
    parameter int WIDTH  = 4,
    parameter int SIGNED = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] BIAS = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

    logic [WIDTH-1:0] a_k;
    logic [WIDTH-1:0] b_k;

    assign a_k = a ^ BIAS;
    assign b_k = b ^ BIAS;
    assign gt  = (a_k > b_k);
    assign lt  = (a_k < b_k);
    assign eq  = (a_k == b_k);

endmodule

// File: rtl/window_extrema.sv
// rtl/window_extrema.sv - streaming windowed max/min/index/above-threshold tracker
module window_extrema
    import window_extrema_pkg::*;
#(
    parameter int  WIDTH  = 4,
    parameter int  DEPTH  = 8,
    parameter int  SIGNED = 0,
    localparam int CW     = cw_of(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] thr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [CW-1:0]    out_max_idx,
    output logic [CW-1:0]    out_min_idx,
    output logic [CW-1:0]    out_above
);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [CW-1:0]    max_idx_q, max_idx_d;
    logic [CW-1:0]    min_idx_q, min_idx_d;
    logic [CW-1:0]    above_q, above_d;

    logic gt_mx, lt_mx, eq_mx;
    logic gt_mn, lt_mn, eq_mn;
    logic gt_th, lt_th, eq_th;
    logic max_upd, min_upd, above_inc;
    logic first, last;

    cmp_core #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp_max (
        .a(in_data), .b(max_q), .gt(gt_mx), .lt(lt_mx), .eq(eq_mx)
    );
    cmp_core #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp_min (
        .a(in_data), .b(min_q), .gt(gt_mn), .lt(lt_mn), .eq(eq_mn)
    );
    cmp_core #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp_thr (
        .a(in_data), .b(thr), .gt(gt_th), .lt(lt_th), .eq(eq_th)
    );

    // Ties never replace an extremum, so the first occurrence keeps its index.
    assign max_upd   = strict_win(gt_mx, eq_mx, lt_mx);
    assign min_upd   = strict_win(lt_mn, eq_mn, gt_mn);
    assign above_inc = strict_win(gt_th, eq_th, lt_th);
    assign first     = (cnt_q == '0);
    assign last      = (cnt_q == CW'(DEPTH - 1));

    assign in_ready    = (state_q == ST_ACC) && !clr;
    assign out_valid   = (state_q == ST_HOLD);
    assign out_max     = max_q;
    assign out_min     = min_q;
    assign out_max_idx = max_idx_q;
    assign out_min_idx = min_idx_q;
    assign out_above   = above_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        max_d     = max_q;
        min_d     = min_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;
        above_d   = above_q;
        case (state_q)
            ST_ACC: begin
                if (clr) begin
                    cnt_d = '0;
                end else if (in_valid) begin
                    if (first) begin
                        max_d     = in_data;
                        min_d     = in_data;
                        max_idx_d = '0;
                        min_idx_d = '0;
                        above_d   = CW'(above_inc);
                    end else begin
                        if (max_upd) begin
                            max_d     = in_data;
                            max_idx_d = cnt_q;
                        end
                        if (min_upd) begin
                            min_d     = in_data;
                            min_idx_d = cnt_q;
                        end
                        above_d = above_q + CW'(above_inc);
                    end
                    if (last) begin
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ACC;
            cnt_q     <= '0;
            max_q     <= '0;
            min_q     <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
            above_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            max_q     <= max_d;
            min_q     <= min_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
            above_q   <= above_d;
        end
    end

endmodule
